pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 core. It watches stage icodes, register IDs, branch outcome and status codes, and generates per-cycle stall/bubble controls for the F, D, E, M and W pipeline registers. It owns a run/halt state machine that freezes the machine once a non-AOK status retires. It also keeps cycle, retired-instruction and stall-cycle counters. It sits beside the pipeline registers, and its outputs drive their stall/bubble inputs directly.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/pipe_perf_cnt.sv | 65 ++++++
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-control types used by the control unit.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ctrl_state_t;

  // Instructions whose result arrives only from data memory.
  function automatic logic is_mem_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Cycle, retired-instruction and stall-cycle counters sharing one enable.
module pipe_perf_cnt
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             retire_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Next-count selection; all counters wrap naturally.
  always_comb begin
    cycle_d   = cycle_q;
    retired_d = retired_q;
    stall_d   = stall_q;
    if (en_i) begin
      cycle_d = cycle_q + CNT_ONE;
      if (retire_i) begin
        retired_d = retired_q + CNT_ONE;
      end else begin
        retired_d = retired_q;
      end
      if (stall_i) begin
        stall_d = stall_q + CNT_ONE;
      end else begin
        stall_d = stall_q;
      end
    end else begin
      cycle_d   = cycle_q;
      retired_d = retired_q;
      stall_d   = stall_q;
    end
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= CNT_ZERO;
      retired_q <= CNT_ZERO;
      stall_q   <= CNT_ZERO;
    end else begin
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign retired_cnt_o = retired_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble generation, run/halt FSM and
// performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_state_t state_q, state_d;
  logic [2:0]  final_stat_q, final_stat_d;

  logic load_use;
  logic ret_pend;
  logic mispred;
  logic exc_m;
  logic exc_w;
  logic run_mode;

  assign load_use = is_mem_load(E_icode) && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispred  = (E_icode == I_JXX) && !e_cnd;
  assign exc_m    = (m_stat != S_AOK);
  assign exc_w    = (W_stat != S_AOK);

  // Reset forces the RUN equations even if the state register still holds HALTED.
  assign run_mode = !rst_n || (state_q == RUN);

  // Stall/bubble controls; D stall has priority over D bubble.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    if (run_mode) begin
      F_stall  = load_use || ret_pend;
      D_stall  = load_use;
      D_bubble = mispred || (ret_pend && !load_use);
      E_bubble = mispred || load_use;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
    end else begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end
  end

  // Run/halt next-state: the first non-AOK retirement freezes the machine.
  always_comb begin
    state_d      = state_q;
    final_stat_d = final_stat_q;
    case (state_q)
      RUN: begin
        if (exc_w) begin
          state_d      = HALTED;
          final_stat_d = W_stat;
        end else begin
          state_d      = RUN;
          final_stat_d = final_stat_q;
        end
      end
      HALTED: begin
        state_d      = HALTED;
        final_stat_d = final_stat_q;
      end
      default: begin
        state_d      = RUN;
        final_stat_d = S_AOK;
      end
    endcase
  end

  // State and halt-cause registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      final_stat_q <= S_AOK;
    end else begin
      state_q      <= state_d;
      final_stat_q <= final_stat_d;
    end
  end

  assign halted     = rst_n && (state_q == HALTED);
  assign final_stat = final_stat_q;

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (state_q == RUN),
    .retire_i     ((W_stat == S_AOK) && (W_icode != I_NOP)),
    .stall_i      (F_stall),
    .cycle_cnt_o  (cycle_cnt),
    .retired_cnt_o(retired_cnt),
    .stall_cnt_o  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  D_icode, E_icode, M_icode, W_icode;
  logic [3:0]  d_srcA, d_srcB, E_dstM;
  logic        e_cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
  logic        halted;
  logic [2:0]  final_stat;
  logic [31:0] cycle_cnt, retired_cnt, stall_cnt;
  logic [5:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  // ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .halted(halted), .final_stat(final_stat),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  task automatic set_idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    n_checks++;
    if (ctl !== 6'b000000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000000", ctl); end
    n_checks++;
    if (halted !== 1'b0 || final_stat !== 3'd1) begin
      n_fail++; $display("FAIL reset_state: halted=%b final_stat=%0d expected 0/1", halted, final_stat);
    end
    n_checks++;
    if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: %0d/%0d/%0d expected 0/0/0", cycle_cnt, retired_cnt, stall_cnt);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    #1;
    n_checks++;
    if (ctl !== 6'b110100) begin n_fail++; $display("FAIL load_use_srcB: got %b expected 110100", ctl); end
    tick();
    n_checks++;
    if (stall_cnt !== 32'd1 || cycle_cnt !== 32'd1) begin
      n_fail++; $display("FAIL load_use_cnt: stall=%0d cycle=%0d expected 1/1", stall_cnt, cycle_cnt);
    end
    E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4; d_srcB = 4'hF;
    #1;
    n_checks++;
    if (ctl !== 6'b110100) begin n_fail++; $display("FAIL load_use_popq: got %b expected 110100", ctl); end
    E_dstM = 4'hF; d_srcA = 4'hF;
    #1;
    n_checks++;
    if (ctl !== 6'b000000) begin n_fail++; $display("FAIL load_use_rnone: got %b expected 000000", ctl); end
    E_icode = 4'h6; E_dstM = 4'h2; d_srcA = 4'h2;
    #1;
    n_checks++;
    if (ctl !== 6'b000000) begin n_fail++; $display("FAIL load_use_nonload: got %b expected 000000", ctl); end
    set_idle();
  endtask

  task automatic test_mispred();
    E_icode = 4'h7; e_cnd = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 6'b001100) begin n_fail++; $display("FAIL mispred: got %b expected 001100", ctl); end
    e_cnd = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 6'b000000) begin n_fail++; $display("FAIL mispred_taken: got %b expected 000000", ctl); end
    set_idle();
  endtask

  task automatic test_ret();
    for (int s = 0; s < 3; s++) begin
      set_idle();
      if (s == 0) D_icode = 4'h9;
      else if (s == 1) E_icode = 4'h9;
      else M_icode = 4'h9;
      #1;
      n_checks++;
      if (ctl !== 6'b101000) begin n_fail++; $display("FAIL ret_stage%0d: got %b expected 101000", s, ctl); end
      tick();
    end
    n_checks++;
    if (cycle_cnt !== 32'd4 || stall_cnt !== 32'd4 || retired_cnt !== 32'd0) begin
      n_fail++; $display("FAIL ret_cnt: %0d/%0d/%0d expected 4/0/4", cycle_cnt, retired_cnt, stall_cnt);
    end
    set_idle();
    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    #1;
    n_checks++;
    if (ctl !== 6'b110100) begin n_fail++; $display("FAIL ret_load_use: got %b expected 110100", ctl); end
    set_idle();
  endtask

  task automatic test_retire();
    for (int i = 0; i < 10; i++) begin
      W_icode = (i % 2 == 0) ? 4'h6 : 4'h1;
      W_stat = 3'd1;
      tick();
    end
    n_checks++;
    if (retired_cnt !== 32'd5 || cycle_cnt !== 32'd14) begin
      n_fail++; $display("FAIL retire_cnt: retired=%0d cycle=%0d expected 5/14", retired_cnt, cycle_cnt);
    end
    set_idle();
  endtask

  task automatic test_exception();
    m_stat = 3'd3;
    #1;
    n_checks++;
    if (ctl !== 6'b000010) begin n_fail++; $display("FAIL exc_m: got %b expected 000010", ctl); end
    tick();
    set_idle();
    W_stat = 3'd3; W_icode = 4'h6; E_icode = 4'h7; e_cnd = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 6'b001111 || halted !== 1'b0) begin
      n_fail++; $display("FAIL exc_w: ctl=%b halted=%b expected 001111/0", ctl, halted);
    end
    tick();
    n_checks++;
    if (halted !== 1'b1 || final_stat !== 3'd3) begin
      n_fail++; $display("FAIL halt_entry: halted=%b final_stat=%0d expected 1/3", halted, final_stat);
    end
    n_checks++;
    if (ctl !== 6'b110111) begin n_fail++; $display("FAIL halt_ctl: got %b expected 110111", ctl); end
    n_checks++;
    if (cycle_cnt !== 32'd16 || retired_cnt !== 32'd5 || stall_cnt !== 32'd4) begin
      n_fail++; $display("FAIL halt_cnt: %0d/%0d/%0d expected 16/5/4", cycle_cnt, retired_cnt, stall_cnt);
    end
    set_idle();
    W_icode = 4'h6; D_icode = 4'h9;
    tick();
    tick();
    tick();
    n_checks++;
    if (ctl !== 6'b110111 || halted !== 1'b1 || final_stat !== 3'd3) begin
      n_fail++; $display("FAIL halt_hold: ctl=%b halted=%b final=%0d expected 110111/1/3", ctl, halted, final_stat);
    end
    n_checks++;
    if (cycle_cnt !== 32'd16 || retired_cnt !== 32'd5 || stall_cnt !== 32'd4) begin
      n_fail++; $display("FAIL halt_frozen: %0d/%0d/%0d expected 16/5/4", cycle_cnt, retired_cnt, stall_cnt);
    end
    set_idle();
  endtask

  task automatic test_reset_halted();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (halted !== 1'b0 || final_stat !== 3'd1 || ctl !== 6'b000000) begin
      n_fail++; $display("FAIL rst_halted_state: halted=%b final=%0d ctl=%b expected 0/1/000000", halted, final_stat, ctl);
    end
    n_checks++;
    if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_halted_cnt: %0d/%0d/%0d expected 0/0/0", cycle_cnt, retired_cnt, stall_cnt);
    end
    E_icode = 4'h5; E_dstM = 4'h7; d_srcA = 4'h7;
    #1;
    n_checks++;
    if (ctl !== 6'b110100) begin n_fail++; $display("FAIL rst_resume_ctl: got %b expected 110100", ctl); end
    tick();
    n_checks++;
    if (cycle_cnt !== 32'd1 || stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL rst_resume_cnt: cycle=%0d stall=%0d expected 1/1", cycle_cnt, stall_cnt);
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mispred();
    test_ret();
    test_retire();
    test_exception();
    test_reset_halted();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
